mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/lc3_mem_pkg.sv | 17 +
 rtl/mem_wait_ctr.sv | 23 ++
 rtl/mem_access_unit.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory access unit.
package lc3_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    FINISH  = 2'd3
  } mau_state_e;

  localparam int WAIT_STATES_DEFAULT = 2;
  localparam int TIMEOUT_DEFAULT     = 8;

  // Value left in MDR when a read is abandoned, so software can spot it.
  localparam logic [15:0] ABORT_FILL = 16'hBEEF;

endpackage

// File: rtl/mem_wait_ctr.sv
// Loadable down-counter that saturates at zero; used for wait and timeout counts.
module mem_wait_ctr #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] count
);

  // Load has priority over decrement; decrement stops at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (dec && (count != '0))
      count <= count - 1'b1;
  end

endmodule

// File: rtl/mem_access_unit.sv
// MAR/MDR pair with a wait-state and timeout controlled memory access sequencer.
module mem_access_unit
  import lc3_mem_pkg::*;
#(
  parameter int WAIT_STATES = WAIT_STATES_DEFAULT,
  parameter int TIMEOUT     = TIMEOUT_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] DataBus,
  input  logic        LD_MAR,
  input  logic        LD_MDR,
  input  logic        MIO_EN,
  input  logic        R,
  input  logic        W,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rdy,
  output logic [15:0] MAR,
  output logic [15:0] MDR_bus,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_ce,
  output logic        mem_oe,
  output logic        mem_we,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int WAIT_W = 4;
  localparam int TO_W   = 8;

  mau_state_e        state;
  mau_state_e        next_state;
  logic [15:0]       mdr;
  logic [WAIT_W-1:0] wait_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic              in_wait;
  logic              wait_zero;
  logic              start_access;
  logic              complete;
  logic              abort;

  assign in_wait      = (state == RD_WAIT) || (state == WR_WAIT);
  assign wait_zero    = (wait_cnt == '0);
  assign start_access = (state == IDLE) && (next_state != IDLE);
  assign complete     = in_wait && wait_zero && mem_rdy;
  // Abort on the cycle the timeout counter would reach zero without mem_rdy.
  assign abort        = in_wait && wait_zero && !mem_rdy && (to_cnt == TO_W'(1));

  mem_wait_ctr #(.WIDTH(WAIT_W)) u_wait_ctr (
    .clk      (Clk),
    .rst_n    (Reset),
    .load     (start_access),
    .load_val (WAIT_W'(WAIT_STATES)),
    .dec      (in_wait),
    .count    (wait_cnt)
  );

  mem_wait_ctr #(.WIDTH(TO_W)) u_timeout_ctr (
    .clk      (Clk),
    .rst_n    (Reset),
    .load     (start_access),
    .load_val (TO_W'(TIMEOUT)),
    .dec      (in_wait && wait_zero && !mem_rdy),
    .count    (to_cnt)
  );

  // State register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  // Next-state logic: reads win over writes; FINISH always returns to IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (R && MIO_EN)
          next_state = RD_WAIT;
        else if (W && !R)
          next_state = WR_WAIT;
      end
      RD_WAIT, WR_WAIT: begin
        if (complete)
          next_state = FINISH;
        else if (abort)
          next_state = IDLE;
      end
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Strobes and status decoded from the current state.
  always_comb begin
    mem_ce = 1'b0;
    mem_oe = 1'b0;
    mem_we = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (state)
      RD_WAIT: begin
        mem_ce = 1'b1;
        mem_oe = 1'b1;
        busy   = 1'b1;
      end
      WR_WAIT: begin
        mem_ce = 1'b1;
        mem_we = 1'b1;
        busy   = 1'b1;
      end
      FINISH: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // One-cycle error pulse on the cycle after a timeout abort.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)
      err <= 1'b0;
    else
      err <= abort;
  end

  // MAR loads only in IDLE so the address is stable during an access.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)
      MAR <= '0;
    else if ((state == IDLE) && LD_MAR)
      MAR <= DataBus;
  end

  // MDR loads from the bus in IDLE, or from memory / the fill value when a read ends.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)
      mdr <= '0;
    else if ((state == IDLE) && LD_MDR && !MIO_EN)
      mdr <= DataBus;
    else if ((state == RD_WAIT) && complete)
      mdr <= mem_rdata;
    else if ((state == RD_WAIT) && abort)
      mdr <= ABORT_FILL;
  end

  assign MDR_bus   = mdr;
  assign mem_addr  = MAR;
  assign mem_wdata = mdr;

endmodule
